// File: rtl/ir_cmd_scheduler.sv
`timescale 1ns/1ps
// ir_cmd_scheduler
//   Takes decoded NEC frames from the IR receiver, validates them, maps the key to a
//   3-bit command, suppresses auto-repeat of the same key, queues accepted commands and
//   hands them one at a time to the UART/JSON sender over valid/ready, with an idle gap
//   after each transfer.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   data_ready      frame-valid level from IR receiver (rising edge = new frame)
//   ir_data[31:0]   frame: [31:24]=~key, [23:16]=key, [15:0]=address
//   cmd_valid/ready command handshake towards the sender, cmd_code = offered command
//   state_control   last command transferred, toggle inverts on every transfer
//   fifo_level      queued entries, drop_count saturating drop counter
//   frame_err       1-cycle pulse for a frame that fails validation
//
// Build option
//   IR_ADDR_FILTER_EN: reject frames whose address differs from CUSTOM_CODE.
module ir_cmd_scheduler #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned HOLDOFF_CYCLES = 25_000_000,
  parameter int unsigned GAP_CYCLES     = 50_000,
  parameter logic [15:0] CUSTOM_CODE    = 16'h6B86
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_ready,
  input  logic [31:0] ir_data,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [2:0]  cmd_code,
  output logic [2:0]  state_control,
  output logic        toggle,
  output logic [2:0]  fifo_level,
  output logic [7:0]  drop_count,
  output logic        frame_err
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned HW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES + 1) : 1;
  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {StIdle, StOffer, StGap} state_e;

  state_e        state_q, state_d;
  logic          dr_q;
  logic [7:0]    last_key_q, last_key_d;
  logic          last_vld_q, last_vld_d;
  logic [HW-1:0] holdoff_q, holdoff_d;
  logic [2:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic [7:0]    drop_q, drop_d;
  logic          frame_err_q, frame_err_d;
  logic [2:0]    cmd_code_q, cmd_code_d;
  logic [2:0]    state_ctl_q, state_ctl_d;
  logic          toggle_q, toggle_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;

  logic       frame_edge, addr_bad, frame_bad, repeat_hit, accept;
  logic       fifo_full, push, pop, drop;
  logic [7:0] key;

  assign key        = ir_data[23:16];
  assign frame_edge = data_ready & ~dr_q;

`ifdef IR_ADDR_FILTER_EN
  assign addr_bad = (ir_data[15:0] != CUSTOM_CODE);
`else
  logic unused_addr;
  assign addr_bad    = 1'b0;
  assign unused_addr = ^{ir_data[15:0], CUSTOM_CODE};
`endif

  assign frame_bad  = addr_bad | (ir_data[31:24] != ~key) | (key > 8'h07);
  assign repeat_hit = last_vld_q && (key == last_key_q) && (holdoff_q != '0);
  assign accept     = frame_edge & ~frame_bad & ~repeat_hit;
  // Fullness is judged at the start of the cycle; a same-cycle pop does not make room.
  assign fifo_full  = (level_q == (AW + 1)'(FIFO_DEPTH));
  assign push       = accept & ~fifo_full;
  assign drop       = frame_edge & (frame_bad | (accept & fifo_full));
  assign pop        = (state_q == StOffer) & cmd_ready;

  // Front end: validation, repeat filter, FIFO bookkeeping, drop counter.
  always_comb begin
    last_key_d  = last_key_q;
    last_vld_d  = last_vld_q;
    holdoff_d   = (holdoff_q != '0) ? holdoff_q - HW'(1) : holdoff_q;
    wr_ptr_d    = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d    = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d     = level_q;
    drop_d      = (drop && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
    frame_err_d = frame_edge & frame_bad;
    if (accept) begin
      last_key_d = key;
      last_vld_d = 1'b1;
      holdoff_d  = HW'(HOLDOFF_CYCLES);
    end
    unique case ({push, pop})
      2'b10:   level_d = level_q + (AW + 1)'(1);
      2'b01:   level_d = level_q - (AW + 1)'(1);
      default: level_d = level_q;
    endcase
  end

  // Dispatch FSM: next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (level_q != '0) state_d = StOffer;
      StOffer: if (cmd_ready) state_d = (GAP_CYCLES == 0) ? StIdle : StGap;
      StGap:   if (gap_cnt_q == '0) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Dispatch datapath.
  always_comb begin
    cmd_code_d  = cmd_code_q;
    state_ctl_d = state_ctl_q;
    toggle_d    = toggle_q;
    gap_cnt_d   = gap_cnt_q;
    unique case (state_q)
      StIdle: if (level_q != '0) cmd_code_d = mem_q[rd_ptr_q];
      StOffer: begin
        if (cmd_ready) begin
          state_ctl_d = cmd_code_q;
          toggle_d    = ~toggle_q;
          gap_cnt_d   = (GAP_CYCLES == 0) ? '0 : GW'(GAP_CYCLES - 1);
        end
      end
      StGap:   if (gap_cnt_q != '0) gap_cnt_d = gap_cnt_q - GW'(1);
      default: ;
    endcase
  end

  // Dispatch FSM: outputs.
  always_comb begin
    cmd_valid = (state_q == StOffer);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // Track the live level so a frame rising during reset is not seen as an edge after.
      dr_q        <= data_ready;
      state_q     <= StIdle;
      last_key_q  <= '0;
      last_vld_q  <= 1'b0;
      holdoff_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      drop_q      <= '0;
      frame_err_q <= 1'b0;
      cmd_code_q  <= '0;
      state_ctl_q <= '0;
      toggle_q    <= 1'b0;
      gap_cnt_q   <= '0;
    end else begin
      dr_q        <= data_ready;
      state_q     <= state_d;
      last_key_q  <= last_key_d;
      last_vld_q  <= last_vld_d;
      holdoff_q   <= holdoff_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      drop_q      <= drop_d;
      frame_err_q <= frame_err_d;
      cmd_code_q  <= cmd_code_d;
      state_ctl_q <= state_ctl_d;
      toggle_q    <= toggle_d;
      gap_cnt_q   <= gap_cnt_d;
    end
  end

  // Queue storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wr_ptr_q] <= key[2:0];
  end

  assign cmd_code      = cmd_code_q;
  assign state_control = state_ctl_q;
  assign toggle        = toggle_q;
  assign fifo_level    = 3'(level_q);
  assign drop_count    = drop_q;
  assign frame_err     = frame_err_q;

endmodule

// File: tb/tb_ir_cmd_scheduler.sv
`timescale 1ns/1ps
module tb_ir_cmd_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_ready;
  logic [31:0] ir_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_code;
  logic [2:0]  state_control;
  logic        toggle;
  logic [2:0]  fifo_level;
  logic [7:0]  drop_count;
  logic        frame_err;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int xfer_code[$];
  int xfer_cyc[$];
  int base;

  ir_cmd_scheduler #(
    .FIFO_DEPTH    (4),
    .HOLDOFF_CYCLES(100),
    .GAP_CYCLES    (4),
    .CUSTOM_CODE   (16'h6B86)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .data_ready   (data_ready),
    .ir_data      (ir_data),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_code     (cmd_code),
    .state_control(state_control),
    .toggle       (toggle),
    .fifo_level   (fifo_level),
    .drop_count   (drop_count),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  // Log every completed transfer with its cycle number.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && cmd_valid && cmd_ready) begin
      xfer_code.push_back(int'(cmd_code));
      xfer_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raises data_ready for one cycle (cycle N); returns in cycle N+1.
  task automatic send(input logic [31:0] frame);
    ir_data    = frame;
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    data_ready = 1'b0;
    ir_data    = '0;
    cmd_ready  = 1'b1;
    repeat (2) tick();
    rst = 1'b0;

    // Reset state
    check("rst_valid", cmd_valid, 0);
    check("rst_code", cmd_code, 0);
    check("rst_stctl", state_control, 0);
    check("rst_toggle", toggle, 0);
    check("rst_level", fifo_level, 0);
    check("rst_drop", drop_count, 0);
    check("rst_ferr", frame_err, 0);

    // 1: key 2, empty FIFO, latency
    send(32'hFD02_6B86);
    check("t1_n1_valid", cmd_valid, 0);
    check("t1_n1_ferr", frame_err, 0);
    tick();
    check("t1_n2_valid", cmd_valid, 1);
    check("t1_n2_code", cmd_code, 2);
    tick();
    check("t1_n3_stctl", state_control, 2);
    check("t1_n3_toggle", toggle, 1);
    check("t1_n3_valid", cmd_valid, 0);

    // 2: bad complement
    do_reset();
    base = xfer_code.size();
    send(32'hFF02_6B86);
    check("t2_ferr", frame_err, 1);
    check("t2_drop", drop_count, 1);
    tick();
    check("t2_ferr_pulse", frame_err, 0);
    repeat (10) tick();
    check("t2_no_xfer", xfer_code.size() - base, 0);
    check("t2_level", fifo_level, 0);

    // 3: repeat suppression, then holdoff expiry, then two distinct keys
    do_reset();
    base = xfer_code.size();
    send(32'hFC03_6B86);
    repeat (49) tick();
    send(32'hFC03_6B86);
    repeat (20) tick();
    check("t3_one_xfer", xfer_code.size() - base, 1);
    check("t3_no_drop", drop_count, 0);
    repeat (130) tick();
    send(32'hFC03_6B86);
    repeat (20) tick();
    check("t3_two_xfer", xfer_code.size() - base, 2);
    check("t3_code", xfer_code[base + 1], 3);
    do_reset();
    base = xfer_code.size();
    send(32'hFC03_6B86);
    tick();
    send(32'hFB04_6B86);
    repeat (30) tick();
    check("t3_b2b_cnt", xfer_code.size() - base, 2);
    check("t3_b2b_first", xfer_code[base], 3);
    check("t3_b2b_second", xfer_code[base + 1], 4);

    // 4: backpressure, FIFO full drop, ordered drain with gaps
    do_reset();
    cmd_ready = 1'b0;
    base = xfer_code.size();
    send(32'hFE01_6B86); tick();
    send(32'hFD02_6B86); tick();
    send(32'hFC03_6B86); tick();
    send(32'hFB04_6B86); tick();
    send(32'hFA05_6B86); tick();
    check("t4_level", fifo_level, 4);
    check("t4_drop", drop_count, 1);
    check("t4_valid", cmd_valid, 1);
    check("t4_head", cmd_code, 1);
    cmd_ready = 1'b1;
    repeat (60) tick();
    check("t4_cnt", xfer_code.size() - base, 4);
    for (int i = 0; i < 4; i++) begin
      if (xfer_code.size() > base + i) check("t4_order", xfer_code[base + i], i + 1);
      if (i > 0 && xfer_code.size() > base + i)
        check("t4_spacing", (xfer_cyc[base + i] - xfer_cyc[base + i - 1]) >= 5, 1);
    end
    check("t4_toggle", toggle, 0);
    check("t4_stctl", state_control, 4);
    check("t4_level_end", fifo_level, 0);

    // 5: reset while offering with 3 queued; a frame rising in the reset cycle is lost
    cmd_ready = 1'b0;
    send(32'hFE01_6B86); tick();
    send(32'hFD02_6B86); tick();
    send(32'hFC03_6B86); tick();
    check("t5_pre_level", fifo_level, 3);
    check("t5_pre_valid", cmd_valid, 1);
    rst        = 1'b1;
    ir_data    = 32'hF906_6B86;
    data_ready = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_valid", cmd_valid, 0);
    check("t5_level", fifo_level, 0);
    check("t5_stctl", state_control, 0);
    check("t5_drop", drop_count, 0);
    repeat (5) tick();
    data_ready = 1'b0;
    check("t5_discard_level", fifo_level, 0);
    check("t5_discard_valid", cmd_valid, 0);
    cmd_ready = 1'b1;

    // 6: foreign address
    do_reset();
    base = xfer_code.size();
    send(32'hFD02_1234);
`ifdef IR_ADDR_FILTER_EN
    check("t6_ferr", frame_err, 1);
    check("t6_drop", drop_count, 1);
    repeat (10) tick();
    check("t6_no_xfer", xfer_code.size() - base, 0);
`else
    check("t6_ferr", frame_err, 0);
    check("t6_drop", drop_count, 0);
    repeat (10) tick();
    check("t6_xfer", xfer_code.size() - base, 1);
    if (xfer_code.size() > base) check("t6_code", xfer_code[base], 2);
`endif

    // 7: key out of range, then drop counter saturation
    do_reset();
    send(32'hF708_6B86);
    check("t7_range_ferr", frame_err, 1);
    check("t7_range_drop", drop_count, 1);
    tick();
    repeat (259) begin
      send(32'hFF02_6B86);
      tick();
    end
    check("t7_sat", drop_count, 8'hFF);
    check("t7_sat_level", fifo_level, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
